// File: rtl/pipe_field_if.sv
// pipe_field_if: bundle between the game-state FSM and the pipe field / renderer / collision checker.
//   frame_tick  : one-cycle frame strobe (master -> field)
//   game_state  : one-hot START/IN_GAME/PAUSE/END (master -> field)
//   speed       : scroll step minus one (master -> field)
//   birdX       : bird X used for pass scoring (master -> field)
//   pipe_x/y    : packed signed pipe coordinates, pipe i in [32i+31:32i] (field -> master)
//   score_count : pipes passed, saturating (field -> master)
//   score_pulse : one-cycle pulse per scoring tick (field -> master)
interface pipe_field_if #(
   parameter int NUM_PIPES = 4,
   parameter int SCORE_W   = 16
);
   logic                            frame_tick;
   logic [3:0]                      game_state;
   logic [1:0]                      speed;
   logic signed [31:0]              birdX;
   logic signed [NUM_PIPES*32-1:0]  pipe_x;
   logic signed [NUM_PIPES*32-1:0]  pipe_y;
   logic [SCORE_W-1:0]              score_count;
   logic                            score_pulse;
   modport master (output frame_tick, game_state, speed, birdX,
                   input  pipe_x, pipe_y, score_count, score_pulse);
   modport slave  (input  frame_tick, game_state, speed, birdX,
                   output pipe_x, pipe_y, score_count, score_pulse);
endinterface

// File: rtl/pipe_field.sv
// pipe_field: NUM_PIPES scrolling pipe pairs with recycling, random gap height and pass scoring.
//   clk   : system clock; state advances only on bus.frame_tick cycles (LFSR runs every clk)
//   rst_n : synchronous active-low reset
//   bus   : pipe_field_if.slave (frame_tick, game_state, speed, birdX in; pipe_x, pipe_y,
//           score_count, score_pulse out)
//   Optional: define PIPE_OSCILLATE_EN to add a shared triangle oscillation of the gap heights.
module pipe_field #(
   parameter int          NUM_PIPES       = 4,
   parameter int          PIPE_SIZE_X     = 78,
   parameter int          PIPE_SEPARATION = 250,
   parameter int          START_X         = 700,
   parameter int          PLAY_H          = 420,
   parameter int          RAND_BITS       = 7,
   parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
   parameter int          SCORE_W         = 16
`ifdef PIPE_OSCILLATE_EN
   ,
   parameter int          OSC_AMP         = 16,
   parameter int          OSC_DIV         = 2
`endif
) (
   input logic         clk,
   input logic         rst_n,
   pipe_field_if.slave bus
);
   localparam int          CENTRE   = (PLAY_H - (1 << RAND_BITS)) / 2;
   localparam int          HW       = $clog2(NUM_PIPES + 1);
   // right-shift Galois mask for x^32+x^22+x^2+x+1
   localparam logic [31:0] TAPS     = 32'h8020_0003;
   localparam logic [3:0]  ST_START = 4'b0001;
   localparam logic [3:0]  ST_GAME  = 4'b0010;

   logic signed [31:0] x_q [NUM_PIPES];
   logic signed [31:0] x_d [NUM_PIPES];
   logic signed [31:0] y_q [NUM_PIPES];
   logic signed [31:0] y_d [NUM_PIPES];
   logic signed [31:0] nx  [NUM_PIPES];
   logic signed [31:0] rx  [NUM_PIPES];
   logic signed [31:0] rnd [NUM_PIPES];
   logic [NUM_PIPES-1:0] rec, hit;
   logic [31:0]        lfsr_q, lfsr_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic               pulse_q, pulse_d;
   logic signed [31:0] step;
   logic [HW-1:0]      hits;
   logic [SCORE_W:0]   sum;
   logic               tick_start, tick_game;

   assign tick_start = bus.frame_tick && bus.game_state == ST_START;
   assign tick_game  = bus.frame_tick && bus.game_state == ST_GAME;
   assign step       = 32'(bus.speed) + 32'sd1;
   assign hits       = HW'($countones(hit));
   assign sum        = {1'b0, score_q} + (SCORE_W+1)'(hits);

`ifdef PIPE_OSCILLATE_EN
   logic signed [31:0] osc_q, osc_d;
   logic               up_q, up_d;
   logic [31:0]        div_q, div_d;

   // triangle turns around at the amplitude limits, stepping once every OSC_DIV game ticks
   always_comb begin
      osc_d = osc_q;
      up_d  = up_q;
      div_d = div_q;
      if (tick_start) begin
         osc_d = '0;
         up_d  = 1'b1;
         div_d = '0;
      end else if (tick_game) begin
         div_d = (div_q == 32'(OSC_DIV - 1)) ? '0 : div_q + 32'd1;
         if (div_q == 32'(OSC_DIV - 1)) begin
            up_d  = (osc_q == OSC_AMP) ? 1'b0 : (osc_q == -OSC_AMP) ? 1'b1 : up_q;
            osc_d = up_d ? osc_q + 32'sd1 : osc_q - 32'sd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         osc_q <= '0;
         up_q  <= 1'b1;
         div_q <= '0;
      end else begin
         osc_q <= osc_d;
         up_q  <= up_d;
         div_q <= div_d;
      end
   end
`endif

   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
      localparam int RS = (g * RAND_BITS) % (33 - RAND_BITS);
      assign nx[g]  = x_q[g] - step;
      // recycled pipe lands behind its predecessor's post-step position
      assign rx[g]  = nx[(g + NUM_PIPES - 1) % NUM_PIPES] + PIPE_SEPARATION;
      assign rnd[g] = CENTRE + 32'(lfsr_q[RS +: RAND_BITS]);
      assign rec[g] = nx[g] + PIPE_SIZE_X <= 0;
      // crossing test, since a step can jump past birdX
      assign hit[g] = (x_q[g] + PIPE_SIZE_X > bus.birdX) && (nx[g] + PIPE_SIZE_X <= bus.birdX);
      assign bus.pipe_x[32*g +: 32] = x_q[g];
`ifdef PIPE_OSCILLATE_EN
      assign bus.pipe_y[32*g +: 32] = (g % 2 == 0) ? y_q[g] + osc_q : y_q[g] - osc_q;
`else
      assign bus.pipe_y[32*g +: 32] = y_q[g];
`endif
   end

   always_comb begin
      lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
      score_d = tick_start ? '0 : tick_game ? (sum[SCORE_W] ? '1 : sum[SCORE_W-1:0]) : score_q;
      pulse_d = tick_game && hits != '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
         x_d[i] = tick_start ? START_X + i * PIPE_SEPARATION :
                  tick_game  ? (rec[i] ? rx[i] : nx[i]) : x_q[i];
         y_d[i] = (tick_start || (tick_game && rec[i])) ? rnd[i] : y_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PIPES; i++) begin
            x_q[i] <= START_X + i * PIPE_SEPARATION;
            y_q[i] <= CENTRE;
         end
         lfsr_q  <= LFSR_SEED;
         score_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         lfsr_q  <= lfsr_d;
         score_q <= score_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.score_count = score_q;
   assign bus.score_pulse = pulse_q;
endmodule

// File: tb/tb_pipe_field.sv
// tb_pipe_field: directed and randomized checks of pipe_field against an arithmetic reference model.
module tb_pipe_field;
   localparam int          NP   = 4;
   localparam int          SW   = 4;
   localparam int          SZ   = 78;
   localparam int          SEP  = 250;
   localparam int          SX   = 700;
   localparam int          CEN  = 146;
   localparam int          RB   = 7;
   localparam int          SMAX = (1 << SW) - 1;
   localparam logic [31:0] SEED = 32'hACE1_2468;
   localparam logic [3:0]  GS_START = 4'b0001;
   localparam logic [3:0]  GS_GAME  = 4'b0010;
   localparam logic [3:0]  GS_PAUSE = 4'b0100;
   localparam logic [3:0]  GS_END   = 4'b1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   int mx [NP];
   int my [NP];
   int msc = 0;
   logic mpl = 1'b0;
   logic [31:0] mlf = '0;

   pipe_field_if #(.NUM_PIPES(NP), .SCORE_W(SW)) bus ();
   pipe_field #(.NUM_PIPES(NP), .SCORE_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
      end
   endtask

   function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
      int taps [4] = '{32, 22, 2, 1};
      logic [31:0] m = '0;
      foreach (taps[t]) m[taps[t]-1] = 1'b1;
      return {1'b0, s[31:1]} ^ (s[0] ? m : 32'd0);
   endfunction

   function automatic int rnd(input int i);
      return CEN + int'((mlf >> ((i * RB) % (33 - RB))) & ((32'd1 << RB) - 32'd1));
   endfunction

   function automatic int px(input int i);
      return $signed(bus.pipe_x[32*i +: 32]);
   endfunction

   function automatic int py(input int i);
      return $signed(bus.pipe_y[32*i +: 32]);
   endfunction

   task automatic compare_all();
      for (int i = 0; i < NP; i++) begin
         check($sformatf("x%0d", i), px(i), mx[i]);
         check($sformatf("y%0d", i), py(i), my[i]);
      end
      check("score", 32'(bus.score_count), msc);
      check("pulse", 32'(bus.score_pulse), 32'(mpl));
   endtask

   task automatic step(input logic rn, input logic ft, input logic [3:0] gs, input int spd, input int bx);
      int nx [NP];
      int tx [NP];
      int ty [NP];
      int k = 0;
      int nsc;
      logic npl = 1'b0;
      @(negedge clk);
      rst_n = rn;
      bus.frame_tick = ft;
      bus.game_state = gs;
      bus.speed = 2'(spd);
      bus.birdX = bx;
      tx = mx;
      ty = my;
      nsc = msc;
      if (!rn) begin
         for (int i = 0; i < NP; i++) begin
            tx[i] = SX + i * SEP;
            ty[i] = CEN;
         end
         nsc = 0;
      end else if (ft && gs == GS_START) begin
         for (int i = 0; i < NP; i++) begin
            tx[i] = SX + i * SEP;
            ty[i] = rnd(i);
         end
         nsc = 0;
      end else if (ft && gs == GS_GAME) begin
         for (int i = 0; i < NP; i++) nx[i] = mx[i] - (spd + 1);
         for (int i = 0; i < NP; i++) begin
            tx[i] = nx[i];
            if (nx[i] + SZ <= 0) begin
               tx[i] = nx[(i + NP - 1) % NP] + SEP;
               ty[i] = rnd(i);
            end
            if (mx[i] + SZ > bx && nx[i] + SZ <= bx) k++;
         end
         nsc = (msc + k > SMAX) ? SMAX : msc + k;
         npl = k > 0;
      end
      @(posedge clk);
      #1;
      mx = tx;
      my = ty;
      msc = nsc;
      mpl = npl;
      mlf = rn ? lfsr_adv(mlf) : SEED;
      compare_all();
   endtask

   initial begin
      int n;
      int p_mod;
      int p_dut;
      int bx;
      int r;
      logic [3:0] gs;
      bus.frame_tick = 1'b0;
      bus.game_state = GS_GAME;
      bus.speed = 2'd0;
      bus.birdX = 100;
      step(1'b0, 1'b0, GS_GAME, 0, 100);
      step(1'b0, 1'b1, GS_GAME, 3, 100);
      for (int i = 0; i < NP; i++) begin
         check($sformatf("rst_x%0d", i), px(i), SX + i * SEP);
         check($sformatf("rst_y%0d", i), py(i), CEN);
      end
      check("rst_score", 32'(bus.score_count), 0);
      step(1'b1, 1'b0, GS_GAME, 3, 100);
      check("idle_hold", px(0), 700);
      repeat (10) step(1'b1, 1'b1, GS_GAME, 0, 100);
      check("scroll_s0", px(0), 690);
      repeat (3) step(1'b1, 1'b0, GS_GAME, 3, 100);
      check("no_tick_hold", px(0), 690);
      repeat (10) step(1'b1, 1'b1, GS_GAME, 3, 100);
      check("scroll_s3", px(0), 650);
      n = 0;
      while (mx[0] > 24 && n < 1000) begin
         step(1'b1, 1'b1, GS_GAME, (mx[0] - 24 >= 4) ? 3 : 0, 100);
         n++;
      end
      check("reach_24", px(0), 24);
      check("pre_pass_score", 32'(bus.score_count), 0);
      step(1'b1, 1'b1, GS_GAME, 3, 100);
      check("pass_score", 32'(bus.score_count), 1);
      check("pass_pulse", 32'(bus.score_pulse), 1);
      step(1'b1, 1'b0, GS_GAME, 3, 100);
      check("pulse_one_cycle", 32'(bus.score_pulse), 0);
      n = 0;
      while (mx[0] > -76 && n < 1000) begin
         step(1'b1, 1'b1, GS_GAME, (mx[0] + 76 >= 4) ? 3 : 0, 100);
         n++;
      end
      check("reach_m76", px(0), -76);
      step(1'b1, 1'b1, GS_GAME, 0, 100);
      check("edge_m77", px(0), -77);
      step(1'b1, 1'b1, GS_GAME, 0, 100);
      check("recycle_x3", px(3), 672);
      check("recycle_x0", px(0), 922);
      check("recycle_y0_range", 32'(py(0) >= 146 && py(0) <= 273), 1);
      check("score_after_recycle", 32'(bus.score_count), 1);
      repeat (20) step(1'b1, 1'b1, GS_PAUSE, int'($urandom_range(0, 3)), 100);
      check("pause_x0", px(0), 922);
      check("pause_score", 32'(bus.score_count), 1);
      step(1'b1, 1'b1, GS_GAME, 3, 100);
      step(1'b0, 1'b1, GS_GAME, 3, 100);
      check("midrst_x0", px(0), 700);
      check("midrst_score", 32'(bus.score_count), 0);
      repeat (5) step(1'b1, 1'b1, GS_GAME, 1, 100);
      step(1'b1, 1'b1, GS_START, 2, 100);
      check("start_x0", px(0), 700);
      check("start_x2", px(2), 1200);
      check("start_score", 32'(bus.score_count), 0);
      for (int i = 0; i < NP; i++)
         check($sformatf("start_y%0d_range", i), 32'(py(i) >= 146 && py(i) <= 273), 1);
      n = 0;
      p_mod = 0;
      p_dut = 0;
      while (p_mod < 18 && n < 5000) begin
         step(1'b1, 1'b1, GS_GAME, 3, 300);
         p_mod += int'(mpl);
         p_dut += int'(bus.score_pulse);
         n++;
      end
      check("sat_bound", 32'(n < 5000), 1);
      check("sat_score", 32'(bus.score_count), 15);
      check("sat_pulses", p_dut, 18);
      bx = 200;
      repeat (4000) begin
         if ($urandom_range(0, 149) == 0) bx = int'($urandom_range(0, 500)) - 50;
         r = int'($urandom_range(0, 99));
         gs = r < 2 ? GS_START : r < 80 ? GS_GAME : r < 88 ? GS_PAUSE : r < 94 ? GS_END : 4'($urandom_range(0, 15));
         step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, gs, int'($urandom_range(0, 3)), bx);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
